dino_game_ctrl: RTL and testbench

//  Game sequencer for the 7-seg dinosaur runner. Generates the game tick from CLOCK_50.

---
 rtl/dino_game_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dino_game_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: game sequencer for the 7-segment dinosaur runner.
// It generates the game tick, spawns obstacles from an LFSR and scrolls them
// toward the player. It also times jumps, detects collisions, keeps the score
// and runs the IDLE -> RUN -> OVER flow. Segment encoding is done downstream.
// Optional build macro DINO_SPEEDUP_EN: the tick period halves at score 64
// and again at score 128. The speed level is re-evaluated on every tick.
module dino_game_ctrl #(
  parameter int          TICK_DIV      = 20000000,
  parameter int          LANES         = 5,
  parameter int          JUMP_TICKS    = 3,
  parameter int          SPAWN_GAP_MIN = 2,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             jump,
  output logic [LANES-1:0] lane_cactus,
  output logic [LANES-1:0] lane_bird,
  output logic             player_up,
  output logic             tick,
  output logic             game_over,
  output logic             running,
  output logic [13:0]      score
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int JMP_W = $clog2(JUMP_TICKS + 1);
  // One spare code so the gap counter can always represent SPAWN_GAP_MIN.
  localparam int GAP_W = $clog2(SPAWN_GAP_MIN + 2);

  logic [1:0]       state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] div_last;
  logic [7:0]       lfsr_reg, lfsr_next;
  logic [LANES-1:0] cactus_reg, cactus_next;
  logic [LANES-1:0] bird_reg, bird_next;
  logic [LANES-1:0] cactus_shift, bird_shift;
  logic             up_reg, up_next;
  logic [JMP_W-1:0] jump_cnt_reg, jump_cnt_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [13:0]      score_reg, score_next;
  logic             start_d_reg, jump_d_reg;
  logic             start_rise, jump_rise;
  logic             tick_now, collision;
  logic             spawn_ok, spawn_cactus, spawn_bird;

`ifdef DINO_SPEEDUP_EN
  logic [1:0] level_reg, level_next;
  assign div_last = DIV_W'((TICK_DIV >> level_reg) - 1);
`else
  assign div_last = DIV_W'(TICK_DIV - 1);
`endif

  assign start_rise = start & ~start_d_reg;
  assign jump_rise  = jump & ~jump_d_reg;

  // The >= comparison keeps the divider safe if the period ever shrinks mid-count.
  assign tick_now  = (state_reg == ST_RUN) && (div_reg >= div_last);
  assign collision = (cactus_reg[LANES-1] & ~up_reg) | (bird_reg[LANES-1] & up_reg);

  // LFSR[1:0]: 00 none, 01 cactus, 10 bird, 11 cactus. The two kinds are exclusive.
  assign spawn_ok     = (gap_reg >= GAP_W'(SPAWN_GAP_MIN));
  assign spawn_cactus = spawn_ok & lfsr_reg[0];
  assign spawn_bird   = spawn_ok & lfsr_reg[1] & ~lfsr_reg[0];

  // Scrolled lane contents, with lane 0 receiving the new spawn.
  assign cactus_shift[0] = spawn_cactus;
  assign bird_shift[0]   = spawn_bird;
  for (genvar gi = 1; gi < LANES; gi++) begin : g_shift
    assign cactus_shift[gi] = cactus_reg[gi-1];
    assign bird_shift[gi]   = bird_reg[gi-1];
  end

  // Next-state logic: game flow, divider, tick actions, jump handling and LFSR.
  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    cactus_next   = cactus_reg;
    bird_next     = bird_reg;
    up_next       = up_reg;
    jump_cnt_next = jump_cnt_reg;
    gap_next      = gap_reg;
    score_next    = score_reg;
`ifdef DINO_SPEEDUP_EN
    level_next    = level_reg;
`endif
    lfsr_next     = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

    case (state_reg)
      ST_IDLE, ST_OVER: begin
        div_next = '0;
        if (start_rise) begin
          state_next    = ST_RUN;
          cactus_next   = '0;
          bird_next     = '0;
          up_next       = 1'b0;
          jump_cnt_next = '0;
          gap_next      = '0;
          score_next    = '0;
`ifdef DINO_SPEEDUP_EN
          level_next    = 2'd0;
`endif
        end
      end
      ST_RUN: begin
        if (tick_now) begin
          div_next = '0;
          if (collision) begin
            // Playfield, score and player stay frozen for the game-over display.
            state_next = ST_OVER;
          end else begin
            cactus_next = cactus_shift;
            bird_next   = bird_shift;
            if (spawn_cactus | spawn_bird) begin
              gap_next = '0;
            end else if (gap_reg < GAP_W'(SPAWN_GAP_MIN)) begin
              gap_next = gap_reg + 1'b1;
            end
            if (score_reg != 14'd9999) begin
              score_next = score_reg + 14'd1;
            end
            if (jump_cnt_reg != '0) begin
              jump_cnt_next = jump_cnt_reg - 1'b1;
              if (jump_cnt_reg == JMP_W'(1)) begin
                up_next = 1'b0;
              end
            end
`ifdef DINO_SPEEDUP_EN
            if (score_next >= 14'd128) begin
              level_next = 2'd2;
            end else if (score_next >= 14'd64) begin
              level_next = 2'd1;
            end else begin
              level_next = 2'd0;
            end
`endif
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
        // A jump coinciding with a tick lands after the tick has used the ground state.
        if (jump_rise && !up_reg && !(tick_now && collision)) begin
          up_next       = 1'b1;
          jump_cnt_next = JMP_W'(JUMP_TICKS);
        end
      end
      default: begin
        state_next = ST_IDLE;
        div_next   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ST_IDLE;
      div_reg      <= '0;
      lfsr_reg     <= LFSR_SEED;
      cactus_reg   <= '0;
      bird_reg     <= '0;
      up_reg       <= 1'b0;
      jump_cnt_reg <= '0;
      gap_reg      <= '0;
      score_reg    <= '0;
      start_d_reg  <= 1'b0;
      jump_d_reg   <= 1'b0;
`ifdef DINO_SPEEDUP_EN
      level_reg    <= 2'd0;
`endif
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      lfsr_reg     <= lfsr_next;
      cactus_reg   <= cactus_next;
      bird_reg     <= bird_next;
      up_reg       <= up_next;
      jump_cnt_reg <= jump_cnt_next;
      gap_reg      <= gap_next;
      score_reg    <= score_next;
      start_d_reg  <= start;
      jump_d_reg   <= jump;
`ifdef DINO_SPEEDUP_EN
      level_reg    <= level_next;
`endif
    end
  end

  assign lane_cactus = cactus_reg;
  assign lane_bird   = bird_reg;
  assign player_up   = up_reg;
  assign tick        = tick_now;
  assign game_over   = (state_reg == ST_OVER);
  assign running     = (state_reg == ST_RUN);
  assign score       = score_reg;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb_dino_game_ctrl: bench for dino_game_ctrl with a behavioural game model.
// The model keeps lanes as an array of obstacle kinds and counts down the
// cycles remaining to the next tick.
module tb_dino_game_ctrl;

  localparam int TICK_DIV      = 4;
  localparam int LANES         = 5;
  localparam int JUMP_TICKS    = 3;
  localparam int SPAWN_GAP_MIN = 2;

  logic             CLOCK_50 = 1'b0;
  logic             RESET_N  = 1'b0;
  logic             start    = 1'b0;
  logic             jump     = 1'b0;
  logic [LANES-1:0] lane_cactus;
  logic [LANES-1:0] lane_bird;
  logic             player_up;
  logic             tick;
  logic             game_over;
  logic             running;
  logic [13:0]      score;

  dino_game_ctrl #(
    .TICK_DIV      (TICK_DIV),
    .LANES         (LANES),
    .JUMP_TICKS    (JUMP_TICKS),
    .SPAWN_GAP_MIN (SPAWN_GAP_MIN),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .start       (start),
    .jump        (jump),
    .lane_cactus (lane_cactus),
    .lane_bird   (lane_bird),
    .player_up   (player_up),
    .tick        (tick),
    .game_over   (game_over),
    .running     (running),
    .score       (score)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: 0 idle, 1 run, 2 over. Lane kinds: 0 empty, 1 cactus, 2 bird.
  int m_state;
  int m_wait;
  int m_lane [LANES];
  int m_up;
  int m_air;
  int m_gap;
  int m_score;
  int m_lfsr;
  int m_start_q;
  int m_jump_q;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int period();
    int lvl;
    lvl = 0;
`ifdef DINO_SPEEDUP_EN
    lvl = m_score / 64;
    if (lvl > 2) lvl = 2;
`endif
    return TICK_DIV >> lvl;
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_up = 0; m_air = 0; m_gap = 0; m_score = 0;
    m_lfsr = 'hA5; m_start_q = 0; m_jump_q = 0;
    for (int i = 0; i < LANES; i++) m_lane[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    int srise, jrise, coll, up_before, kind;
    srise = (start && m_start_q == 0) ? 1 : 0;
    jrise = (jump && m_jump_q == 0) ? 1 : 0;
    coll = 0;
    up_before = m_up;
    if (m_state == 1) begin
      if (m_wait == 1) begin
        coll = ((m_lane[LANES-1] == 1 && m_up == 0) || (m_lane[LANES-1] == 2 && m_up == 1)) ? 1 : 0;
        if (coll != 0) begin
          m_state = 2;
        end else begin
          kind = 0;
          if (m_gap >= SPAWN_GAP_MIN) begin
            case (m_lfsr % 4)
              0: kind = 0;
              2: kind = 2;
              default: kind = 1;
            endcase
          end
          m_gap = (kind != 0) ? 0 : m_gap + 1;
          for (int i = LANES - 1; i > 0; i--) m_lane[i] = m_lane[i-1];
          m_lane[0] = kind;
          if (m_score < 9999) m_score++;
          if (m_air > 0) begin
            m_air--;
            if (m_air == 0) m_up = 0;
          end
          m_wait = period();
        end
      end else begin
        m_wait--;
      end
      if (coll == 0 && jrise != 0 && up_before == 0) begin
        m_up = 1;
        m_air = JUMP_TICKS;
      end
    end else if (srise != 0) begin
      m_state = 1; m_wait = TICK_DIV; m_up = 0; m_air = 0; m_gap = 0; m_score = 0;
      for (int i = 0; i < LANES; i++) m_lane[i] = 0;
    end
    m_lfsr = ((m_lfsr << 1) & 'hFF) | ($countones(m_lfsr & 'hB8) % 2);
    m_start_q = start ? 1 : 0;
    m_jump_q  = jump ? 1 : 0;
  endtask

  task automatic compare_all();
    int ec, eb;
    ec = 0; eb = 0;
    for (int i = 0; i < LANES; i++) begin
      if (m_lane[i] == 1) ec |= (1 << i);
      if (m_lane[i] == 2) eb |= (1 << i);
    end
    check_val("lane_cactus", int'(lane_cactus), ec);
    check_val("lane_bird", int'(lane_bird), eb);
    check_val("player_up", int'(player_up), m_up);
    check_val("tick", int'(tick), (m_state == 1 && m_wait == 1) ? 1 : 0);
    check_val("game_over", int'(game_over), (m_state == 2) ? 1 : 0);
    check_val("running", int'(running), (m_state == 1) ? 1 : 0);
    check_val("score", int'(score), m_score);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_outs"},
              int'(lane_cactus) + int'(lane_bird) + int'(player_up) + int'(tick) +
              int'(game_over) + int'(running) + int'(score), 0);
  endtask

  // One clock: drive inputs on the falling edge, model the rising edge, sample after it.
  task automatic cycle(input logic s, input logic j);
    @(negedge CLOCK_50);
    start = s;
    jump  = j;
    @(posedge CLOCK_50);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    RESET_N = 1'b0;
    start = 1'b0;
    jump  = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge CLOCK_50);
    #2;
    RESET_N = 1'b1;
  endtask

  int tick_cnt;
  int up_rises;
  int prev_up;
  int reached;

  initial begin
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #2;
    RESET_N = 1'b1;
    #1;
    check_all_zero("reset");

    // Idle without start: no tick may appear.
    tick_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0);
      if (tick) tick_cnt++;
    end
    check_val("idle_ticks", tick_cnt, 0);

    // Start and watch the first three ticks.
    cycle(1'b1, 1'b0);
    check_val("run_entry", int'(running), 1);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b0);
      check_val("first_score", int'(score), k / 4);
      check_val("first_tick", int'(tick), (k % 4 == 3) ? 1 : 0);
      if (k == 8) check_val("early_lanes01", int'(lane_cactus[1:0]) + int'(lane_bird[1:0]), 0);
    end

    // Held jump yields a single jump; a start pulse inside RUN changes nothing.
    up_rises = 0;
    prev_up = int'(player_up);
    for (int i = 0; i < 40; i++) begin
      cycle((i == 20) ? 1'b1 : 1'b0, 1'b1);
      if (player_up && prev_up == 0) up_rises++;
      prev_up = int'(player_up);
    end
    check_val("held_jump_count", up_rises, 1);

    // Random play against the model, with an asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) == 0) ? ~jump : jump);
      if (i == 1500) begin
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        do_reset();
      end
    end

    // Play without jumping until a cactus ends the game, then restart.
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    reached = 0;
    for (int i = 0; i < 800 && reached == 0; i++) begin
      cycle(1'b0, 1'b0);
      if (game_over) reached = 1;
    end
    check_val("over_reached", reached, 1);
    repeat (8) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check_val("restart_running", int'(running), 1);
    check_val("restart_score", int'(score), 0);
    check_val("restart_lanes", int'(lane_cactus) + int'(lane_bird), 0);
    repeat (20) cycle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
